// File: rtl/bus_pkg.sv
// Shared definitions for the memory-bus responder: FSM state encoding,
// the wait-state ceiling, and the write-protect address comparison.
package bus_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_ACK    = 3'd4;

    // The strobe counter is four bits wide, so this is the longest stretch it can hold.
    localparam int WAIT_STATES_MAX = 15;

    typedef enum logic [2:0] {
        IDLE   = S_IDLE,
        SETUP  = S_SETUP,
        STROBE = S_STROBE,
        HOLD   = S_HOLD,
        ACK    = S_ACK
    } state_t;

    // True when a bus address lies below the protected boot region.
    // The comparison always uses the full 16-bit bus address, whatever the SRAM width.
    function automatic logic in_rom(input logic [15:0] addr, input int rom_bytes);
        return ({16'h0000, addr} < $unsigned(rom_bytes));
    endfunction

endpackage

// File: rtl/sram_bus_responder.sv
// Slave end of the shared Z80 memory bus. Each level-held request becomes
// one timed cycle on an async 8-bit SRAM. Read data and ack are held until
// the active master releases cs or presents a different request.
// All SRAM strobes are flop outputs that follow the FSM state one cycle
// later, so nothing reaching the pads is combinational from the bus.
module sram_bus_responder
    import bus_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 1,
    parameter int ROM_BYTES   = 0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [15:0]       i_addr,
    input  logic [7:0]        i_dat,
    input  logic              i_we,
    input  logic              i_cs,
    output logic [7:0]        o_dat,
    output logic              o_ack,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [7:0]        o_sram_dq,
    input  logic [7:0]        i_sram_dq,
    output logic              o_sram_dq_oe,
    output logic              o_sram_ce_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n
);

    // Strobe length reload value, clamped to what the counter can represent.
    localparam logic [3:0] WAIT_INIT =
        4'((WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES);

    state_t      state;
    logic [15:0] addr_q;
    logic        we_q;
    logic        prot_q;
    logic        abort_q;
    logic [3:0]  wait_cnt;
    logic        sample_rd;
    logic        in_access;
    logic        req_match;

    // Decode of the current state and of whether the bus still shows the
    // request that is being served; both feed only flop inputs below.
    always_comb begin
        in_access = (state == SETUP) || (state == STROBE) || (state == HOLD);
        req_match = (i_addr == addr_q) && (i_we == we_q);
    end

    // Access sequencer with registered SRAM strobes, ack and read data.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            prot_q       <= 1'b0;
            abort_q      <= 1'b0;
            wait_cnt     <= '0;
            sample_rd    <= 1'b0;
            o_dat        <= '0;
            o_ack        <= 1'b0;
            o_sram_addr  <= '0;
            o_sram_dq    <= '0;
            o_sram_dq_oe <= 1'b0;
            o_sram_ce_n  <= 1'b1;
            o_sram_oe_n  <= 1'b1;
            o_sram_we_n  <= 1'b1;
        end else begin
            o_sram_ce_n  <= !in_access;
            o_sram_dq_oe <= in_access && we_q;
            o_sram_oe_n  <= !((state == STROBE) && !we_q);
            o_sram_we_n  <= !((state == STROBE) && we_q && !prot_q);
            o_ack        <= (state == ACK) && i_cs && req_match;
            sample_rd    <= (state == STROBE) && !we_q && (wait_cnt == 4'd0);
            if (sample_rd) begin
                o_dat <= i_sram_dq;
            end

            case (state)
                IDLE: begin
                    if (i_cs && !o_ack) begin
                        addr_q      <= i_addr;
                        we_q        <= i_we;
                        prot_q      <= i_we && in_rom(i_addr, ROM_BYTES);
                        abort_q     <= 1'b0;
                        o_sram_addr <= i_addr[ADDR_W-1:0];
                        o_sram_dq   <= i_dat;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    wait_cnt <= WAIT_INIT;
                    if (!i_cs) begin
                        abort_q <= 1'b1;
                    end
                    state <= STROBE;
                end
                STROBE: begin
                    if (!i_cs) begin
                        abort_q <= 1'b1;
                    end
                    if (wait_cnt == 4'd0) begin
                        if (we_q) begin
                            state <= HOLD;
                        end else if (abort_q || !i_cs) begin
                            state <= IDLE;
                        end else begin
                            state <= ACK;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (abort_q || !i_cs) begin
                        state <= IDLE;
                    end else begin
                        state <= ACK;
                    end
                end
                ACK: begin
                    if (!i_cs || !req_match) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_bus_responder.sv
// Directed bench for sram_bus_responder with a behavioural async SRAM.
// Instance: WAIT_STATES=1, ROM_BYTES=0x0100.
// Edge counts are taken from the edge that samples the request (inclusive),
// so ack at N+4 is the 5th edge for a read and N+5 the 6th for a write.
module tb_sram_bus_responder;

    localparam int READ_EDGES  = 5;
    localparam int WRITE_EDGES = 6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] addr;
    logic [7:0]  dat;
    logic        we;
    logic        cs;
    logic [7:0]  rd_dat;
    logic        ack;
    logic [15:0] sram_addr;
    logic [7:0]  sram_dq_out;
    logic [7:0]  sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    int checks   = 0;
    int failures = 0;

    // Monitor counters, written only by the monitor process.
    int   oe_low_cnt     = 0;
    int   we_low_cnt     = 0;
    int   we_pulse_cnt   = 0;
    int   ack_high_cnt   = 0;
    int   strobe_bad_cnt = 0;
    logic prev_we_n      = 1'b1;
    logic [7:0] dq_exp   = 8'h00;

    logic [7:0] mem [0:65535];
    logic       mem_loaded = 1'b0;

    sram_bus_responder #(
        .ADDR_W      (16),
        .WAIT_STATES (1),
        .ROM_BYTES   (16'h0100)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_addr       (addr),
        .i_dat        (dat),
        .i_we         (we),
        .i_cs         (cs),
        .o_dat        (rd_dat),
        .o_ack        (ack),
        .o_sram_addr  (sram_addr),
        .o_sram_dq    (sram_dq_out),
        .i_sram_dq    (sram_dq_in),
        .o_sram_dq_oe (sram_dq_oe),
        .o_sram_ce_n  (sram_ce_n),
        .o_sram_oe_n  (sram_oe_n),
        .o_sram_we_n  (sram_we_n)
    );

    always #5 clk = ~clk;

    // SRAM model: preloaded on the first edge, then written while ce_n and we_n are low.
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 65536; i++) begin
                mem[i] <= 8'h00;
            end
            mem[16'h1234] <= 8'hA5;
            mem[16'h0010] <= 8'h42;
            mem[16'h0200] <= 8'h11;
            mem[16'h0300] <= 8'h22;
            mem_loaded    <= 1'b1;
        end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            mem[sram_addr] <= sram_dq_out;
        end
    end

    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 8'hEE;

    // Strobe monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (!sram_oe_n) oe_low_cnt++;
        if (!sram_we_n) we_low_cnt++;
        if (!sram_we_n && prev_we_n) we_pulse_cnt++;
        if (ack) ack_high_cnt++;
        if (!sram_we_n && (sram_ce_n || !sram_dq_oe || !sram_oe_n || sram_dq_out != dq_exp))
            strobe_bad_cnt++;
        prev_we_n = sram_we_n;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic c, input logic w, input logic [15:0] a,
                                 input logic [7:0] d);
        cs   = c;
        we   = w;
        addr = a;
        dat  = d;
    endtask

    task automatic waitAck(output int edges);
        edges = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ack) begin
                edges = i;
                break;
            end
        end
    endtask

    // Full read: request, wait for ack, check latency and data, release.
    task automatic doRead(input string tag, input logic [15:0] a, input logic [7:0] exp_dat);
        int lat;
        applyStimulus(1'b1, 1'b0, a, 8'h00);
        waitAck(lat);
        checkOutput({tag, "_lat"}, lat, READ_EDGES);
        checkOutput({tag, "_dat"}, rd_dat, exp_dat);
        applyStimulus(1'b0, 1'b0, a, 8'h00);
        tick();
    endtask

    // Full write: request, wait for ack, check latency and strobe counts, release.
    task automatic doWrite(input string tag, input logic [15:0] a, input logic [7:0] d,
                           input int exp_pulses);
        int lat;
        int p0;
        int l0;
        p0     = we_pulse_cnt;
        l0     = we_low_cnt;
        dq_exp = d;
        applyStimulus(1'b1, 1'b1, a, d);
        waitAck(lat);
        checkOutput({tag, "_lat"}, lat, WRITE_EDGES);
        applyStimulus(1'b0, 1'b1, a, d);
        tick();
        checkOutput({tag, "_pulses"}, we_pulse_cnt - p0, exp_pulses);
        checkOutput({tag, "_we_low"}, we_low_cnt - l0, 2 * exp_pulses);
    endtask

    initial begin
        int lat;
        int o0;
        int a0;
        int l0;
        int p0;

        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        checkOutput("rst_ack",   ack,        1'b0);
        checkOutput("rst_ce_n",  sram_ce_n,  1'b1);
        checkOutput("rst_oe_n",  sram_oe_n,  1'b1);
        checkOutput("rst_we_n",  sram_we_n,  1'b1);
        checkOutput("rst_dq_oe", sram_dq_oe, 1'b0);
        checkOutput("rst_dat",   rd_dat,     8'h00);
        checkOutput("rst_addr",  sram_addr,  16'h0000);

        // Read 0x1234 with ack held for several cycles.
        o0 = oe_low_cnt;
        applyStimulus(1'b1, 1'b0, 16'h1234, 8'h00);
        waitAck(lat);
        checkOutput("rd1_lat",  lat, READ_EDGES);
        checkOutput("rd1_dat",  rd_dat, 8'hA5);
        checkOutput("rd1_addr", sram_addr, 16'h1234);
        checkOutput("rd1_oe",   oe_low_cnt - o0, 2);
        repeat (3) tick();
        checkOutput("rd1_hold_ack", ack, 1'b1);
        checkOutput("rd1_hold_dat", rd_dat, 8'hA5);
        applyStimulus(1'b0, 1'b0, 16'h1234, 8'h00);
        tick();
        checkOutput("rd1_drop_ack", ack, 1'b0);

        // Write 0x3C to 0x8001; bus data changes after latching are ignored.
        p0     = we_pulse_cnt;
        l0     = we_low_cnt;
        dq_exp = 8'h3C;
        applyStimulus(1'b1, 1'b1, 16'h8001, 8'h3C);
        tick();
        dat = 8'hC3;
        waitAck(lat);
        checkOutput("wr2_lat", lat + 1, WRITE_EDGES);
        applyStimulus(1'b0, 1'b1, 16'h8001, 8'hC3);
        tick();
        checkOutput("wr2_drop_ack", ack, 1'b0);
        checkOutput("wr2_pulses", we_pulse_cnt - p0, 1);
        checkOutput("wr2_we_low", we_low_cnt - l0, 2);
        doRead("rd2", 16'h8001, 8'h3C);

        // Write-protected region and its boundary.
        doWrite("wr3_rom", 16'h0010, 8'hFF, 0);
        doRead("rd3_rom", 16'h0010, 8'h42);
        doWrite("wr3_ff", 16'h00FF, 8'h99, 0);
        doWrite("wr3_edge", 16'h0100, 8'hAB, 1);
        doRead("rd3_edge", 16'h0100, 8'hAB);

        // cs released during the write strobe.
        p0     = we_pulse_cnt;
        l0     = we_low_cnt;
        a0     = ack_high_cnt;
        dq_exp = 8'h77;
        applyStimulus(1'b1, 1'b1, 16'h9000, 8'h77);
        tick();
        tick();
        applyStimulus(1'b0, 1'b1, 16'h9000, 8'h77);
        repeat (8) tick();
        checkOutput("ab4_ack", ack_high_cnt - a0, 0);
        checkOutput("ab4_pulses", we_pulse_cnt - p0, 1);
        checkOutput("ab4_we_low", we_low_cnt - l0, 2);
        checkOutput("ab4_ce_n", sram_ce_n, 1'b1);
        doRead("rd4", 16'h9000, 8'h77);

        // Master switch while acked.
        applyStimulus(1'b1, 1'b0, 16'h0200, 8'h00);
        waitAck(lat);
        checkOutput("sw5_lat_a", lat, READ_EDGES);
        checkOutput("sw5_dat_a", rd_dat, 8'h11);
        addr = 16'h0300;
        tick();
        checkOutput("sw5_ack_drop", ack, 1'b0);
        waitAck(lat);
        checkOutput("sw5_lat_b", lat, READ_EDGES);
        checkOutput("sw5_dat_b", rd_dat, 8'h22);
        applyStimulus(1'b0, 1'b0, 16'h0300, 8'h00);
        tick();

        // Reset asserted during a write strobe.
        dq_exp = 8'h55;
        applyStimulus(1'b1, 1'b1, 16'hA000, 8'h55);
        repeat (3) tick();
        checkOutput("rs6_we_pre", sram_we_n, 1'b0);
        reset_n = 1'b0;
        tick();
        checkOutput("rs6_we_n",  sram_we_n,  1'b1);
        checkOutput("rs6_ce_n",  sram_ce_n,  1'b1);
        checkOutput("rs6_dq_oe", sram_dq_oe, 1'b0);
        checkOutput("rs6_ack",   ack,        1'b0);
        checkOutput("rs6_dat",   rd_dat,     8'h00);
        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
        repeat (2) tick();
        checkOutput("rs6_ack_after", ack, 1'b0);
        doRead("rd6", 16'h1234, 8'hA5);

        checkOutput("strobe_integrity", strobe_bad_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
